// File: rtl/picobello_clint.sv
// Core-local interruptor for the Picobello harts: a 64-bit mtime, per-hart mtimecmp/msip/dbgreq
// registers on a simple register bus, and a round-robin scanner that shares one 64-bit comparator.

package picobello_clint_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } csh_reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } csh_reg_rsp_t;
endpackage

module picobello_clint #(
   parameter int unsigned NumHarts = 144,
   parameter type reg_req_t = picobello_clint_pkg::csh_reg_req_t,
   parameter type reg_rsp_t = picobello_clint_pkg::csh_reg_rsp_t
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                rtc_i,
   input  reg_req_t            reg_req_i,
   output reg_rsp_t            reg_rsp_o,
   output logic [NumHarts-1:0] msip_o,
   output logic [NumHarts-1:0] mtip_o,
   output logic [NumHarts-1:0] debug_req_o
);

   localparam int unsigned IdxW = (NumHarts > 1) ? $clog2(NumHarts) : 1;

   typedef enum logic {IDLE, RESP} state_e;
   typedef enum logic [2:0] {R_NONE, R_MSIP, R_CMP, R_MTIME, R_DBG} region_e;

   state_e              state_q;
   logic                ready_q;
   logic                error_q;
   logic [31:0]         rdata_q;
   logic [NumHarts-1:0] msip_q;
   logic [NumHarts-1:0] dbg_q;
   logic [NumHarts-1:0] mtip_q;
   logic [63:0]         mtimecmp_q [NumHarts];
   logic [63:0]         mtime_q;
   logic [63:0]         mtime_inc;
   logic [63:0]         mtime_d;
   logic [2:0]          rtc_sync_q;
   logic                tick;
   logic [IdxW-1:0]     idx_q;
   logic [15:0]         off;
   logic [11:0]         hart;
   logic [IdxW-1:0]     hsel;
   logic                hi_half;
   region_e             region;
   logic [31:0]         rdata_d;
   logic                accept;
   logic                wr_en;
   logic                addr_unused;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                         input logic [3:0] wstrb);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

   // The bus demux has already selected this block, so only the low 16 address bits matter.
   assign off         = reg_req_i.addr[15:0];
   assign addr_unused = ^reg_req_i.addr;
   assign hsel        = hart[IdxW-1:0];

   always_comb begin
      region  = R_NONE;
      hart    = '0;
      hi_half = 1'b0;
      if (off < 16'h4000) begin
         region = R_MSIP;
         hart   = off[13:2];
      end else if (off < 16'hBFF8) begin
         region  = R_CMP;
         hart    = 12'((off - 16'h4000) >> 3);
         hi_half = off[2];
      end else if (off < 16'hC000) begin
         region  = R_MTIME;
         hi_half = off[2];
      end else begin
         region = R_DBG;
         hart   = off[13:2];
      end
      if (region != R_MTIME && 32'(hart) >= NumHarts) region = R_NONE;
   end

   always_comb begin
      rdata_d = '0;
      case (region)
         R_MSIP:  rdata_d = {31'b0, msip_q[hsel]};
         R_DBG:   rdata_d = {31'b0, dbg_q[hsel]};
         R_CMP:   rdata_d = hi_half ? mtimecmp_q[hsel][63:32] : mtimecmp_q[hsel][31:0];
         R_MTIME: rdata_d = hi_half ? mtime_q[63:32] : mtime_q[31:0];
         default: rdata_d = '0;
      endcase
   end

   assign accept = (state_q == IDLE) && reg_req_i.valid;
   assign wr_en  = accept && reg_req_i.write && (region != R_NONE);
   assign tick   = rtc_sync_q[1] & ~rtc_sync_q[2];

   // A software write to MTIME overrides only the strobed bytes of the already-ticked value.
   always_comb begin
      mtime_inc = mtime_q + 64'(tick);
      mtime_d   = mtime_inc;
      if (wr_en && region == R_MTIME) begin
         if (hi_half) mtime_d[63:32] = merge(mtime_inc[63:32], reg_req_i.wdata, reg_req_i.wstrb);
         else         mtime_d[31:0]  = merge(mtime_inc[31:0], reg_req_i.wdata, reg_req_i.wstrb);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rtc_sync_q <= '0;
         mtime_q    <= '0;
      end else begin
         rtc_sync_q <= {rtc_sync_q[1:0], rtc_i};
         mtime_q    <= mtime_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         msip_q <= '0;
         dbg_q  <= '0;
         for (int unsigned i = 0; i < NumHarts; i++) mtimecmp_q[i] <= '1;
      end else if (wr_en) begin
         case (region)
            R_MSIP: if (reg_req_i.wstrb[0]) msip_q[hsel] <= reg_req_i.wdata[0];
            R_DBG:  if (reg_req_i.wstrb[0]) dbg_q[hsel] <= reg_req_i.wdata[0];
            R_CMP: begin
               if (hi_half)
                  mtimecmp_q[hsel][63:32] <= merge(mtimecmp_q[hsel][63:32], reg_req_i.wdata,
                                                   reg_req_i.wstrb);
               else
                  mtimecmp_q[hsel][31:0] <= merge(mtimecmp_q[hsel][31:0], reg_req_i.wdata,
                                                  reg_req_i.wstrb);
            end
            default: ;
         endcase
      end
   end

   // One hart per cycle shares the single 64-bit comparator.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q  <= '0;
         mtip_q <= '0;
      end else begin
         mtip_q[idx_q] <= (mtime_q >= mtimecmp_q[idx_q]);
         idx_q         <= (idx_q == IdxW'(NumHarts - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         error_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (reg_req_i.valid) begin
                  state_q <= RESP;
                  ready_q <= 1'b1;
                  error_q <= (region == R_NONE);
                  rdata_q <= reg_req_i.write ? 32'h0 : rdata_d;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
               error_q <= 1'b0;
               rdata_q <= '0;
            end
         endcase
      end
   end

   always_comb begin
      reg_rsp_o       = '0;
      reg_rsp_o.rdata = rdata_q;
      reg_rsp_o.error = error_q;
      reg_rsp_o.ready = ready_q;
   end

   assign msip_o      = msip_q;
   assign debug_req_o = dbg_q;
   assign mtip_o      = mtip_q;

endmodule

// File: tb/tb_picobello_clint.sv
// Directed bench for picobello_clint: a table of single register accesses followed by
// hand-written sequences for ticking, timer compare, wrap and write/tick collision.

module tb_picobello_clint;
   import picobello_clint_pkg::*;

   localparam int NH = 144;

   typedef struct {
      logic          wr;
      logic [31:0]   addr;
      logic [31:0]   wdata;
      logic [3:0]    wstrb;
      logic [31:0]   exp_rdata;
      logic          exp_err;
      logic [NH-1:0] exp_msip;
      logic [NH-1:0] exp_dbg;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rtc = 1'b0;
   csh_reg_req_t  req;
   csh_reg_rsp_t  rsp;
   logic [NH-1:0] msip, mtip, dbg;
   logic [NH-1:0] m0, m3, m5, d2;
   logic          mon_en = 1'b0;
   logic          other_seen = 1'b0;
   int            checks = 0;
   int            errors = 0;
   vec_t          vecs[$];

   picobello_clint #(.NumHarts(NH)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .rtc_i      (rtc),
      .reg_req_i  (req),
      .reg_rsp_o  (rsp),
      .msip_o     (msip),
      .mtip_o     (mtip),
      .debug_req_o(dbg)
   );

   always #5 clk = ~clk;

   // Flags any timer interrupt other than hart 3 while the timer sequence runs.
   always @(negedge clk) begin
      if (mon_en && (mtip & ~m3) != '0) other_seen = 1'b1;
   end

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [NH-1:0] act, input logic [NH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic driveReq(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
      req.addr  = addr;
      req.write = wr;
      req.wdata = wdata;
      req.wstrb = wstrb;
      req.valid = 1'b1;
   endtask

   task automatic finishReq(output logic [31:0] rdata, output logic err, output int lat,
                            output logic [NH-1:0] msip_at, output logic [NH-1:0] dbg_at);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!rsp.ready && lat < 8);
      if (!rsp.ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL bus_timeout: got no ready expected ready");
      end
      rdata   = rsp.rdata;
      err     = rsp.error;
      msip_at = msip;
      dbg_at  = dbg;
      req     = '0;
      @(posedge clk); #1;
   endtask

   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, output logic [31:0] rdata, output logic err,
                                output int lat, output logic [NH-1:0] msip_at,
                                output logic [NH-1:0] dbg_at);
      driveReq(wr, addr, wdata, wstrb);
      finishReq(rdata, err, lat, msip_at, dbg_at);
   endtask

   task automatic wr32(input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] rd; logic e; int l; logic [NH-1:0] a, b;
      applyStimulus(1'b1, addr, wdata, 4'hF, rd, e, l, a, b);
   endtask

   task automatic rdCheck(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] rd; logic e; int l; logic [NH-1:0] a, b;
      applyStimulus(1'b0, addr, 32'h0, 4'h0, rd, e, l, a, b);
      checkOutput(name, rd, exp);
   endtask

   task automatic rtcPulse();
      rtc = 1'b1;
      repeat (4) @(posedge clk);
      #1 rtc = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic wr, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                               logic [31:0] er, logic ee, logic [NH-1:0] em, logic [NH-1:0] ed);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = d; v.wstrb = s;
      v.exp_rdata = er; v.exp_err = ee; v.exp_msip = em; v.exp_dbg = ed;
      return v;
   endfunction

   initial begin
      logic [31:0]   rd;
      logic          e;
      int            l, n;
      logic [NH-1:0] ma, da;

      req = '0;
      m0 = '0; m0[0] = 1'b1;
      m3 = '0; m3[3] = 1'b1;
      m5 = '0; m5[5] = 1'b1;
      d2 = '0; d2[2] = 1'b1;

      vecs.push_back(mk(0, 32'hBFF8, 0, 4'h0, 32'h0, 0, '0, '0));
      vecs.push_back(mk(0, 32'hBFFC, 0, 4'h0, 32'h0, 0, '0, '0));
      vecs.push_back(mk(0, 32'h4000, 0, 4'h0, 32'hFFFF_FFFF, 0, '0, '0));
      vecs.push_back(mk(0, 32'h447C, 0, 4'h0, 32'hFFFF_FFFF, 0, '0, '0));
      vecs.push_back(mk(1, 32'h0014, 1, 4'hF, 32'h0, 0, m5, '0));
      vecs.push_back(mk(0, 32'h0014, 0, 4'h0, 32'h1, 0, m5, '0));
      vecs.push_back(mk(1, 32'hC008, 1, 4'hF, 32'h0, 0, m5, d2));
      vecs.push_back(mk(0, 32'hC008, 0, 4'h0, 32'h1, 0, m5, d2));
      vecs.push_back(mk(1, 32'h0240, 1, 4'hF, 32'h0, 1, m5, d2));
      vecs.push_back(mk(0, 32'h0240, 0, 4'h0, 32'h0, 1, m5, d2));
      vecs.push_back(mk(1, 32'h8000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, m5, d2));
      vecs.push_back(mk(0, 32'hBFF0, 0, 4'h0, 32'h0, 1, m5, d2));
      vecs.push_back(mk(0, 32'hC240, 0, 4'h0, 32'h0, 1, m5, d2));
      vecs.push_back(mk(1, 32'h0010, 1, 4'hE, 32'h0, 0, m5, d2));
      vecs.push_back(mk(0, 32'h0010, 0, 4'h0, 32'h0, 0, m5, d2));
      vecs.push_back(mk(1, 32'h0000, 32'hFFFF_FFFF, 4'hF, 32'h0, 0, m5 | m0, d2));
      vecs.push_back(mk(0, 32'h0000, 0, 4'h0, 32'h1, 0, m5 | m0, d2));
      vecs.push_back(mk(1, 32'h0000, 0, 4'hF, 32'h0, 0, m5, d2));
      vecs.push_back(mk(1, 32'h0014, 0, 4'hF, 32'h0, 0, '0, d2));
      vecs.push_back(mk(1, 32'hC008, 32'hFFFF_FFFE, 4'hF, 32'h0, 0, '0, '0));
      vecs.push_back(mk(0, 32'hC008, 0, 4'h0, 32'h0, 0, '0, '0));
      vecs.push_back(mk(0, 32'h4000, 0, 4'h0, 32'hFFFF_FFFF, 0, '0, '0));

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_msip", msip, '0);
      checkOutput("reset_mtip", mtip, '0);
      checkOutput("reset_dbg", dbg, '0);
      checkOutput("reset_rsp", NH'(rsp), '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, e, l, ma, da);
         checkOutput($sformatf("vec%0d_latency", i), NH'(l), NH'(1));
         checkOutput($sformatf("vec%0d_error", i), NH'(e), NH'(vecs[i].exp_err));
         if (!vecs[i].wr || vecs[i].exp_err)
            checkOutput($sformatf("vec%0d_rdata", i), NH'(rd), NH'(vecs[i].exp_rdata));
         checkOutput($sformatf("vec%0d_msip", i), ma, vecs[i].exp_msip);
         checkOutput($sformatf("vec%0d_dbg", i), da, vecs[i].exp_dbg);
      end
      checkOutput("table_mtip_idle", mtip, '0);

      // Timer on hart 3: equality at mtime = 5 must raise the interrupt.
      wr32(32'h4018, 32'h5);
      wr32(32'h401C, 32'h0);
      rdCheck("cmp3_lo", 32'h4018, 32'h5);
      repeat (NH + 2) @(posedge clk);
      #1 checkOutput("mtip_before_ticks", mtip, '0);
      mon_en = 1'b1;
      repeat (4) rtcPulse();
      repeat (NH + 2) @(posedge clk);
      #1 checkOutput("mtip3_at_4", NH'(mtip[3]), NH'(0));
      rtcPulse();
      n = 0;
      while (!mtip[3] && n < NH + 8) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("mtip3_rise", NH'(mtip[3]), NH'(1));
      repeat (5) rtcPulse();
      rdCheck("mtime_lo_10", 32'hBFF8, 32'd10);
      rdCheck("mtime_hi_10", 32'hBFFC, 32'd0);
      mon_en = 1'b0;
      checkOutput("mtip_others_quiet", NH'(other_seen), NH'(0));

      wr32(32'h401C, 32'hFFFF_FFFF);
      n = 0;
      while (mtip[3] && n < NH + 2) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("mtip3_fall", NH'(mtip[3]), NH'(0));

      // Wrap from all-ones to zero with a single tick.
      wr32(32'hBFF8, 32'hFFFF_FFFF);
      wr32(32'hBFFC, 32'hFFFF_FFFF);
      rdCheck("mtime_hi_ones", 32'hBFFC, 32'hFFFF_FFFF);
      rtcPulse();
      rdCheck("wrap_lo", 32'hBFF8, 32'h0);
      rdCheck("wrap_hi", 32'hBFFC, 32'h0);

      // Collision: tick is high during the cycle in which the write is accepted.
      rtc = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 driveReq(1'b1, 32'hBFF8, 32'h1234, 4'hF);
      finishReq(rd, e, l, ma, da);
      checkOutput("collide_latency", NH'(l), NH'(1));
      rtc = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rdCheck("collide_lo", 32'hBFF8, 32'h1234);
      rdCheck("collide_hi", 32'hBFFC, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/picobello_clint.md
# picobello_clint

Core-local interruptor for the Picobello compute harts. It sits on one of Cheshire's external register-bus ports and drives the per-hart `msip`, `mtip` and `debug_req` inputs of the cluster tiles and the FhG SPU tile, which are currently tied to zero in the top level. It keeps a 64-bit `mtime` counter that advances on the real-time clock, and holds one `mtimecmp` and one `msip` bit per hart. A sequential round-robin scanner compares `mtime` against each `mtimecmp`, so the block needs only one 64-bit comparator.

## Interface
Parameters:
- `NumHarts`, default 144: number of harts served. Index = global hart ID − 1, because Cheshire is hart 0. Legal range 1..2048.
- `reg_req_t`, default `csh_reg_req_t`: register request type. Fields used: `addr`, `write`, `wdata[31:0]`, `wstrb[3:0]`, `valid`.
- `reg_rsp_t`, default `csh_reg_rsp_t`: register response type. Fields used: `rdata[31:0]`, `error`, `ready`.

Ports:
- `clk_i`  in  1  system clock; single clock domain.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `rtc_i`  in  1  real-time clock; asynchronous to `clk_i`.
- `reg_req_i`  in  `reg_req_t`  register request from Cheshire.
- `reg_rsp_o`  out  `reg_rsp_t`  register response.
- `msip_o`  out  `NumHarts`  software interrupt, one bit per hart.
- `mtip_o`  out  `NumHarts`  timer interrupt, one bit per hart.
- `debug_req_o`  out  `NumHarts`  debug request, one bit per hart.

## Operation
Register map (byte offsets; 32-bit accesses; `addr[1:0]` ignored; `h` = hart index):
- `0x0000 + 4h`: MSIP[h]. Only bit 0 is implemented; other bits read 0.
- `0x4000 + 8h`: MTIMECMP[h] low word. `0x4004 + 8h`: MTIMECMP[h] high word.
- `0xBFF8`: MTIME low word. `0xBFFC`: MTIME high word.
- `0xC000 + 4h`: DBGREQ[h]. Only bit 0 is implemented.
- Error cases: any other offset, or any `h ≥ NumHarts`, responds with `error`=1 and `rdata`=0, and no state changes.
- Write strobes: `wstrb` applies per byte. A 64-bit value is written as two independent 32-bit halves; the pair is not atomic.

Bus FSM:
- IDLE → RESP when `valid`=1. A write commits at this same clock edge. Read data is captured into a register at this edge.
- RESP: `ready`=1 with registered `rdata` and `error`. Next state is always IDLE.
- In IDLE, `ready`=0. The requester holds `valid` until it sees `ready`. Throughput is at most one access every 2 cycles.

mtime:
- `rtc_i` passes through a 2-FF synchronizer, then a rising-edge detector, which produces a 1-cycle `tick`.
- On `tick`, mtime ← mtime + 1, modulo 2^64; all-ones wraps to 0.
- If a software write to either MTIME half coincides with `tick`, the written bytes win and the other bytes take the incremented value.

Scanner:
- Counter `idx` runs 0..NumHarts−1 and wraps to 0.
- Every cycle: `mtip_o[idx]` ← (mtime ≥ MTIMECMP[idx]), unsigned 64-bit compare using the register values at that clock edge. Then `idx` increments.
- A MTIMECMP write or mtime change is reflected on `mtip_o` within NumHarts+1 cycles.

Outputs:
- `msip_o[h]` and `debug_req_o[h]` are direct register outputs of MSIP[h] bit 0 and DBGREQ[h] bit 0.
- `mtip_o` is registered.

## Timing
Reset values:
- `mtime` = 0.
- Every MTIMECMP = 0xFFFF_FFFF_FFFF_FFFF.
- MSIP, DBGREQ, `msip_o`, `mtip_o`, `debug_req_o` = 0.
- `idx` = 0, synchronizer flops = 0, FSM = IDLE, `reg_rsp_o` = 0.

Latencies:
- Register access: `ready` rises 1 cycle after `valid` is first sampled.
- MSIP / DBGREQ write: the output changes in the cycle after the accept edge, coincident with `ready`.
- `rtc_i` rising edge to `mtime` increment: 3–4 `clk_i` cycles, depending on the synchronizer phase.
- `mtip_o` update: 1 to NumHarts cycles after a compare input changes.

Boundary conditions:
- Reset asserted mid-access: the FSM returns to IDLE immediately; the pending request gets no response; any commit that already happened stays committed until reset clears it.
- `rtc_i` faster than `clk_i`/4 is unsupported; ticks may be lost.
- NumHarts = 1: `idx` stays at 0, and `mtip_o[0]` updates every cycle.

## Test plan
- Reset: with `rst_ni` low, all outputs are 0. After release, a read of `0xBFF8` returns 0 and a read of `0x4000` returns 0xFFFF_FFFF, each with `ready` exactly 1 cycle after `valid`.
- MSIP and DBGREQ: write 1 to `0x0014` → `msip_o[5]`=1 in the `ready` cycle and reads back 1. Write `0xC008`=1 → `debug_req_o[2]`=1. Write 0 to each → both clear.
- Ticking: apply 10 `rtc_i` rising edges, each 8 clk apart → MTIME low reads 10 and high reads 0.
- Timer: write MTIMECMP[3] = 5, then tick to mtime = 5 → `mtip_o[3]` rises within NumHarts+1 cycles and no other `mtip_o` bit rises. Rewrite MTIMECMP[3] high word to 0xFFFF_FFFF → `mtip_o[3]` falls within NumHarts+1 cycles.
- Wrap and collision: write MTIME = all-ones, then one tick → MTIME = 0. A write of 0x1234 to `0xBFF8` in the same cycle as a tick → low word reads 0x1234.
- Error: read `0x0000 + 4·NumHarts` and write `0x8000` → `error`=1 and `rdata`=0 on both, and no register or output changes.
